qtps_writeback: RTL and testbench
=================================

QTPS_WRITEBACK -- requirements
Module: qtps_writeback

Interface
REQ-001 Parameter DATA_WIDTH, default qtpa_pkg::DATA_WIDTH, datapath width.
REQ-002 Parameter REG_ADDR_W, default 4, register-file address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  execute stage presents a completed instruction.
REQ-006 in_ready  output  1  stage can accept; transfer when in_valid && in_ready.
REQ-007 in_op  input  op_t  decoded operation.
REQ-008 in_rd  input  REG_ADDR_W  destination register.
REQ-009 in_result  input  DATA_WIDTH  ALU result.
REQ-010 in_zero, in_carry, in_ovf  input  1 each  ALU flags.
REQ-011 wb_stall  input  1  register-file port busy; blocks commit.
REQ-012 rf_we  output  1  register-file write enable.
REQ-013 rf_waddr  output  REG_ADDR_W  write address.
REQ-014 rf_wdata  output  DATA_WIDTH  write data.
REQ-015 flag_z, flag_c, flag_v  output  1 each  architectural flags.
REQ-016 lc_dec  input  1  loop-branch unit requests loop-counter decrement.
REQ-017 lc_value  output  DATA_WIDTH  loop counter (Elevator) value.
REQ-018 lc_zero  output  1  lc_value == 0.
REQ-019 fwd_valid  output  1  stage holds a register-writing instruction.
REQ-020 fwd_rd, fwd_data  output  REG_ADDR_W / DATA_WIDTH  forwarding tag/data.

Function
REQ-021 The block SHALL hold one-entry stage register {valid_q, op_q, rd_q, result_q, z_q, c_q, v_q}.
REQ-022 in_ready SHALL equal !valid_q || !wb_stall (combinational).
REQ-023 On transfer, stage register SHALL load inputs and set valid_q; otherwise on commit, clear valid_q; otherwise hold.
REQ-024 Commit SHALL occur in a cycle where valid_q && !wb_stall; minimum latency transfer-to-commit is 1 cycle; throughput 1/cycle when wb_stall low.
REQ-025 Reg-writing ops: ADD, SUB, AND, OR, MOV, SHL, SHR (IMM and REG forms); CMP, LCSET and all other op_t values SHALL NOT write.
REQ-026 rf_we SHALL be 1 only on commit of a reg-writing op with rd_q != 0; rf_waddr = rd_q, rf_wdata = result_q.
REQ-027 Writes to register 0 SHALL be suppressed (rf_we low) but still commit.
REQ-028 Flags SHALL update from z_q/c_q/v_q at commit of ADD, SUB, AND, OR, CMP, MOV, SHL, SHR; LCSET and other ops leave flags unchanged.
REQ-029 Flag outputs SHALL be registered; updated values visible the cycle after commit.
REQ-030 LCSET commit SHALL load lc_value with result_q, full DATA_WIDTH.
REQ-031 lc_dec with lc_value != 0 and no LCSET commit SHALL decrement lc_value by 1.
REQ-032 lc_dec with lc_value == 0 SHALL leave it 0 (saturate, no wrap).
REQ-033 LCSET commit coincident with lc_dec: load SHALL win, decrement dropped.
REQ-034 lc_zero SHALL be combinational from lc_value.
REQ-035 fwd_valid SHALL equal valid_q && reg-writing op && rd_q != 0, independent of wb_stall; fwd_rd = rd_q, fwd_data = result_q.
REQ-036 Held instruction under wb_stall SHALL keep all stage fields stable; in_valid changes ignored while in_ready low.

Reset
REQ-037 While rst high: valid_q=0, flags=0, lc_value=0; hence in_ready=1, rf_we=0, fwd_valid=0, lc_zero=1.
REQ-038 Reset SHALL take priority over transfer, commit, LCSET and lc_dec in the same cycle; an in-flight instruction is discarded.

Verification
REQ-039 ADD_REG rd=3 result=0x0005 z=0 c=1 v=0, no stall -> next cycle rf_we=1, waddr=3, wdata=0x0005; following cycle flag_c=1, flag_z=0.
REQ-040 CMP_IMM result=0 z=1 -> rf_we stays 0, fwd_valid 0; flag_z=1 after commit.
REQ-041 MOV_IMM rd=2 with wb_stall high 3 cycles -> in_ready=0, rf_we=0, fwd_valid=1 fwd_rd=2 for 3 cycles; commit on 4th cycle.
REQ-042 LCSET result=2, then lc_dec x3 -> lc_value 2,1,0,0; lc_zero=1 after second dec; flags unchanged.
REQ-043 LCSET result=7 committed with lc_dec high same cycle -> lc_value=7.
REQ-044 Valid ADD rd=5 in stage, assert rst one cycle -> no rf_we, valid_q=0, flags=0, lc_value=0, in_ready=1.

Source files
------------

// File: rtl/qtps_writeback.sv
// Writeback stage: a one-entry holding register that commits ALU results to the
// register file, updates the architectural flags and owns the loop counter.
package qtpa_pkg;
    parameter int DATA_WIDTH = 16;

    typedef enum logic [4:0] {
        OP_NOP,
        OP_ADD_IMM, OP_ADD_REG,
        OP_SUB_IMM, OP_SUB_REG,
        OP_AND_IMM, OP_AND_REG,
        OP_OR_IMM,  OP_OR_REG,
        OP_MOV_IMM, OP_MOV_REG,
        OP_SHL_IMM, OP_SHL_REG,
        OP_SHR_IMM, OP_SHR_REG,
        OP_CMP_IMM, OP_CMP_REG,
        OP_LCSET,
        OP_LOOP,
        OP_HALT
    } op_t;
endpackage

module qtps_writeback #(
    parameter int DATA_WIDTH = qtpa_pkg::DATA_WIDTH,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  qtpa_pkg::op_t         in_op,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  in_zero,
    input  logic                  in_carry,
    input  logic                  in_ovf,
    input  logic                  wb_stall,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  flag_v,
    input  logic                  lc_dec,
    output logic [DATA_WIDTH-1:0] lc_value,
    output logic                  lc_zero,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [DATA_WIDTH-1:0] fwd_data
);
    import qtpa_pkg::*;

    logic                  valid_q;
    op_t                   op_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  z_q, c_q, v_q;
    logic [DATA_WIDTH-1:0] lc_q;

    logic transfer, commit, op_writes, op_flags, writes_rf;

    always_comb begin
        op_writes = 1'b0;
        op_flags  = 1'b0;
        case (op_q)
            OP_ADD_IMM, OP_ADD_REG, OP_SUB_IMM, OP_SUB_REG,
            OP_AND_IMM, OP_AND_REG, OP_OR_IMM,  OP_OR_REG,
            OP_MOV_IMM, OP_MOV_REG, OP_SHL_IMM, OP_SHL_REG,
            OP_SHR_IMM, OP_SHR_REG: begin
                op_writes = 1'b1;
                op_flags  = 1'b1;
            end
            OP_CMP_IMM, OP_CMP_REG: op_flags = 1'b1;
            default: ;
        endcase
    end

    // Outputs are gated by rst so nothing escapes from an entry that reset discards.
    assign in_ready  = rst || !valid_q || !wb_stall;
    assign transfer  = in_valid && in_ready && !rst;
    assign commit    = valid_q && !wb_stall && !rst;
    assign writes_rf = op_writes && (rd_q != '0);

    assign rf_we     = commit && writes_rf;
    assign rf_waddr  = rd_q;
    assign rf_wdata  = result_q;
    assign fwd_valid = valid_q && writes_rf && !rst;
    assign fwd_rd    = rd_q;
    assign fwd_data  = result_q;
    assign lc_value  = lc_q;
    assign lc_zero   = (lc_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (transfer) begin
            valid_q  <= 1'b1;
            op_q     <= in_op;
            rd_q     <= in_rd;
            result_q <= in_result;
            z_q      <= in_zero;
            c_q      <= in_carry;
            v_q      <= in_ovf;
        end else if (commit) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else if (commit && op_flags) begin
            flag_z <= z_q;
            flag_c <= c_q;
            flag_v <= v_q;
        end
    end

    // LCSET load beats a same-cycle decrement; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (rst)
            lc_q <= '0;
        else if (commit && op_q == OP_LCSET)
            lc_q <= result_q;
        else if (lc_dec && lc_q != '0)
            lc_q <= lc_q - DATA_WIDTH'(1);
    end
endmodule

// File: tb/tb_qtps_writeback.sv
// Random-stimulus bench for qtps_writeback against a queue-based reference model.
module tb_qtps_writeback;
    import qtpa_pkg::*;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    op_t           in_op;
    logic [AW-1:0] in_rd;
    logic [DW-1:0] in_result;
    logic          in_zero, in_carry, in_ovf, wb_stall;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          flag_z, flag_c, flag_v;
    logic          lc_dec;
    logic [DW-1:0] lc_value;
    logic          lc_zero;
    logic          fwd_valid;
    logic [AW-1:0] fwd_rd;
    logic [DW-1:0] fwd_data;

    always #5 clk = ~clk;

    qtps_writeback #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_result(in_result),
        .in_zero(in_zero), .in_carry(in_carry), .in_ovf(in_ovf),
        .wb_stall(wb_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .lc_dec(lc_dec), .lc_value(lc_value), .lc_zero(lc_zero),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    typedef struct {
        op_t           op;
        logic [AW-1:0] rd;
        logic [DW-1:0] res;
        logic [2:0]    zcv;
    } ent_t;

    ent_t          stage_q[$];   // accepted instructions awaiting commit
    bit            m_occ = 0;    // model stage holds stage_q[0]
    logic [2:0]    m_flags = '0;
    logic [DW-1:0] m_lc = '0;
    bit            run = 1;
    int            n_pass = 0, n_total = 0;

    function automatic bit f_wr(op_t op);
        return op inside {OP_ADD_IMM, OP_ADD_REG, OP_SUB_IMM, OP_SUB_REG,
                          OP_AND_IMM, OP_AND_REG, OP_OR_IMM, OP_OR_REG,
                          OP_MOV_IMM, OP_MOV_REG, OP_SHL_IMM, OP_SHL_REG,
                          OP_SHR_IMM, OP_SHR_REG};
    endfunction

    function automatic bit f_fl(op_t op);
        return f_wr(op) || op inside {OP_CMP_IMM, OP_CMP_REG};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // Stimulus: drive a random cycle, then record what the stage must accept.
    initial begin
        rst = 1; in_valid = 0; in_op = OP_NOP; in_rd = '0; in_result = '0;
        in_zero = 0; in_carry = 0; in_ovf = 0; wb_stall = 0; lc_dec = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            rst       = (cyc < 2) || ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_op     = op_t'(5'($urandom_range(0, 19)));
            in_rd     = AW'($urandom_range(0, 15));
            in_result = (in_op == OP_LCSET) ? DW'($urandom_range(0, 6)) : DW'($urandom);
            {in_zero, in_carry, in_ovf} = 3'($urandom);
            wb_stall  = ($urandom_range(0, 3) == 0);
            lc_dec    = $urandom_range(0, 1) != 0;
            if (!rst && in_valid && (!m_occ || !wb_stall))
                stage_q.push_back('{in_op, in_rd, in_result, {in_zero, in_carry, in_ovf}});
        end
        @(posedge clk); #1;
        run = 0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Monitor: compare this cycle's outputs, then advance the model one cycle.
    always @(negedge clk) begin
        ent_t h;
        bit   com, ew, fv;
        if (run) begin
            h   = '{OP_NOP, '0, '0, '0};
            if (m_occ) h = stage_q[0];
            com = m_occ && !wb_stall && !rst;
            ew  = com && f_wr(h.op) && h.rd != 0;
            fv  = !rst && m_occ && f_wr(h.op) && h.rd != 0;

            chk("in_ready", 32'(in_ready), 32'(rst || !m_occ || !wb_stall));
            chk("rf_we", 32'(rf_we), 32'(ew));
            if (rf_we && ew) begin
                chk("rf_waddr", 32'(rf_waddr), 32'(h.rd));
                chk("rf_wdata", 32'(rf_wdata), 32'(h.res));
            end
            chk("fwd_valid", 32'(fwd_valid), 32'(fv));
            if (fwd_valid && fv) begin
                chk("fwd_rd", 32'(fwd_rd), 32'(h.rd));
                chk("fwd_data", 32'(fwd_data), 32'(h.res));
            end
            chk("flags_zcv", 32'({flag_z, flag_c, flag_v}), 32'(m_flags));
            chk("lc_value", 32'(lc_value), 32'(m_lc));
            chk("lc_zero", 32'(lc_zero), 32'(m_lc == 0));

            if (rst) begin
                stage_q.delete();
                m_flags = '0;
                m_lc    = '0;
            end else begin
                if (com) begin
                    void'(stage_q.pop_front());
                    if (f_fl(h.op)) m_flags = h.zcv;
                end
                if (com && h.op == OP_LCSET) m_lc = h.res;
                else if (lc_dec && m_lc != 0) m_lc = m_lc - 1;
            end
            m_occ = stage_q.size() > 0;
        end
    end
endmodule
